me_search_ctrl: RTL

Parametrised search sequencer and best-match tracker for the full-search motion estimator. It consumes the per-candidate SAD stream produced by the PE array and walks a rectangular search window in raster order, across one or more reference frames. It keeps the minimum SAD with its (x, y, ref) position and returns the result over a valid/ready handshake. Compared with the previous control unit, it adds non-square template blocks and windows, multi-reference search, threshold-based early termination and a back-pressured result port.

---
 rtl/me_search_ctrl_if.sv | 45 ++++
 rtl/me_search_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/me_search_ctrl_if.sv
// Request, candidate-SAD stream and best-match result bundle for me_search_ctrl.
// Derived widths are computed from the same geometry parameters the controller uses.
interface me_search_ctrl_if #(
  parameter int TB_W         = 16,
  parameter int TB_H         = 16,
  parameter int SW_W         = 64,
  parameter int SW_H         = 64,
  parameter int NUM_REF      = 1,
  parameter int PE_OUT_WIDTH = 8
);
  localparam int NX        = SW_W - TB_W + 1;
  localparam int NY        = SW_H - TB_H + 1;
  localparam int NCAND     = NX * NY * NUM_REF;
  localparam int SAD_WIDTH = $clog2(TB_W * TB_H) + PE_OUT_WIDTH;
  localparam int MVX_W     = (NX > 1) ? $clog2(NX) : 1;
  localparam int MVY_W     = (NY > 1) ? $clog2(NY) : 1;
  localparam int REF_W     = (NUM_REF > 1) ? $clog2(NUM_REF) : 1;
  localparam int CNT_WIDTH = $clog2(NCAND + 1);

  logic                 req;
  logic                 early_en;
  logic [SAD_WIDTH-1:0] early_thr;
  logic [SAD_WIDTH-1:0] sad;
  logic                 sad_valid;
  logic                 pe_clr;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready;
  logic [SAD_WIDTH-1:0] min_sad;
  logic [MVX_W-1:0]     min_mv_x;
  logic [MVY_W-1:0]     min_mv_y;
  logic [REF_W-1:0]     min_ref;
  logic                 early_hit;
  logic [CNT_WIDTH-1:0] cand_cnt;

  modport master (
    output req, early_en, early_thr, sad, sad_valid, res_ready,
    input  pe_clr, busy, res_valid, min_sad, min_mv_x, min_mv_y, min_ref, early_hit, cand_cnt
  );

  modport slave (
    input  req, early_en, early_thr, sad, sad_valid, res_ready,
    output pe_clr, busy, res_valid, min_sad, min_mv_x, min_mv_y, min_ref, early_hit, cand_cnt
  );
endinterface

// File: rtl/me_search_ctrl.sv
// Full-search sequencer: walks the window in raster order over all references,
// tracks the strict minimum SAD with its position, optional threshold early exit.
module me_search_ctrl #(
  parameter int TB_W         = 16,
  parameter int TB_H         = 16,
  parameter int SW_W         = 64,
  parameter int SW_H         = 64,
  parameter int NUM_REF      = 1,
  parameter int PE_OUT_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  me_search_ctrl_if.slave bus
);
  localparam int NX        = SW_W - TB_W + 1;
  localparam int NY        = SW_H - TB_H + 1;
  localparam int NCAND     = NX * NY * NUM_REF;
  localparam int SAD_WIDTH = $clog2(TB_W * TB_H) + PE_OUT_WIDTH;
  localparam int MVX_W     = (NX > 1) ? $clog2(NX) : 1;
  localparam int MVY_W     = (NY > 1) ? $clog2(NY) : 1;
  localparam int REF_W     = (NUM_REF > 1) ? $clog2(NUM_REF) : 1;
  localparam int CNT_WIDTH = $clog2(NCAND + 1);

  localparam logic [MVX_W-1:0] X_LAST = MVX_W'(NX - 1);
  localparam logic [MVY_W-1:0] Y_LAST = MVY_W'(NY - 1);
  localparam logic [REF_W-1:0] R_LAST = REF_W'(NUM_REF - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]           state;
  logic [MVX_W-1:0]     x_cnt;
  logic [MVY_W-1:0]     y_cnt;
  logic [REF_W-1:0]     ref_cnt;
  logic [CNT_WIDTH-1:0] cand_q;
  logic                 early_en_q;
  logic [SAD_WIDTH-1:0] early_thr_q;
  logic                 pe_clr_q;
  logic                 early_hit_q;
  logic [SAD_WIDTH-1:0] min_sad_q;
  logic [MVX_W-1:0]     min_x_q;
  logic [MVY_W-1:0]     min_y_q;
  logic [REF_W-1:0]     min_ref_q;

  logic better;
  logic at_last;
  logic thr_hit;

  // cand_q == 0 marks the first candidate, which must load regardless of the stale minimum
  assign better  = (cand_q == '0) || (bus.sad < min_sad_q);
  assign at_last = (x_cnt == X_LAST) && (y_cnt == Y_LAST) && (ref_cnt == R_LAST);
  assign thr_hit = early_en_q && (bus.sad <= early_thr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      x_cnt       <= '0;
      y_cnt       <= '0;
      ref_cnt     <= '0;
      cand_q      <= '0;
      early_en_q  <= 1'b0;
      early_thr_q <= '0;
      pe_clr_q    <= 1'b0;
      early_hit_q <= 1'b0;
      min_sad_q   <= '1;
      min_x_q     <= '0;
      min_y_q     <= '0;
      min_ref_q   <= '0;
    end else begin
      pe_clr_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            state       <= S_SEARCH;
            early_en_q  <= bus.early_en;
            early_thr_q <= bus.early_thr;
            x_cnt       <= '0;
            y_cnt       <= '0;
            ref_cnt     <= '0;
            cand_q      <= '0;
            early_hit_q <= 1'b0;
            pe_clr_q    <= 1'b1;
          end
        end
        S_SEARCH: begin
          if (bus.sad_valid) begin
            cand_q <= cand_q + CNT_WIDTH'(1);
            if (better) begin
              min_sad_q <= bus.sad;
              min_x_q   <= x_cnt;
              min_y_q   <= y_cnt;
              min_ref_q <= ref_cnt;
            end
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              if (y_cnt == Y_LAST) begin
                y_cnt   <= '0;
                ref_cnt <= ref_cnt + REF_W'(1);
              end else begin
                y_cnt <= y_cnt + MVY_W'(1);
              end
            end else begin
              x_cnt <= x_cnt + MVX_W'(1);
            end
            if (at_last || thr_hit) begin
              state       <= S_DONE;
              early_hit_q <= thr_hit;
            end
          end
        end
        S_DONE: begin
          if (bus.res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pe_clr    = pe_clr_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.res_valid = (state == S_DONE);
  assign bus.min_sad   = min_sad_q;
  assign bus.min_mv_x  = min_x_q;
  assign bus.min_mv_y  = min_y_q;
  assign bus.min_ref   = min_ref_q;
  assign bus.early_hit = early_hit_q;
  assign bus.cand_cnt  = cand_q;
endmodule
